pp_buf_gen: RTL

- Generalised N-slot ping-pong stage buffer for the encoder pipeline; one instance replaces the fixed two-bank per-stage buffers.
- Producer stage writes one slot while the consumer stage reads an earlier committed slot.
- Slot ownership is tracked in hardware: write/commit and read/release handshakes, slot-occupancy counter, per-slot poly ID tag.
- Read width is a parametrised multiple of write width, so stage re-packing (e.g. 1 coeff in, CHANNEL_NUM coeffs out) is done here.

---
 rtl/pp_buf_gen.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pp_buf_gen.sv
// pp_buf_gen: N-slot ping-pong stage buffer with write/commit and read/release
// slot ownership, per-slot ID tag and RD_RATIO:1 read re-packing.
// Optional feature macro: PP_BUF_STALL_CNT_EN adds wr_stall_cnt / rd_stall_cnt.
//
// Handshake: wr_ready and rd_valid are registered views of the pre-cycle
// occupancy. A write, commit, read or release takes effect only when its
// ready/valid flag is high in that same cycle. When the flag is low the strobe
// is dropped and the sticky err flag is set.
module pp_buf_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_RATIO   = 4,
    parameter int DEPTH      = 4096,
    parameter int NUM_SLOTS  = 2,
    parameter int LATENCY    = 1,
    parameter int ID_WIDTH   = 11
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic                                 wr_ready,
    input  logic                                 wr_en,
    input  logic [$clog2(DEPTH)-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 wr_commit,
    input  logic [ID_WIDTH-1:0]                  wr_id,
    output logic                                 rd_valid,
    output logic [ID_WIDTH-1:0]                  rd_id,
    input  logic                                 rd_en,
    input  logic [$clog2(DEPTH/RD_RATIO)-1:0]    rd_addr,
    output logic [DATA_WIDTH*RD_RATIO-1:0]       rd_data,
    output logic                                 rd_data_vld,
    input  logic                                 rd_release,
    output logic [$clog2(NUM_SLOTS+1)-1:0]       occupancy,
    output logic                                 err
`ifdef PP_BUF_STALL_CNT_EN
    ,
    output logic [31:0]                          wr_stall_cnt,
    output logic [31:0]                          rd_stall_cnt
`endif
);

    localparam int AW       = $clog2(DEPTH);
    localparam int RAW      = $clog2(DEPTH / RD_RATIO);
    localparam int BANK_LOG = $clog2(RD_RATIO);
    localparam int PTR_W    = $clog2(NUM_SLOTS);
    localparam int OCC_W    = $clog2(NUM_SLOTS + 1);
    localparam int RDW      = DATA_WIDTH * RD_RATIO;
    localparam int ROWS     = NUM_SLOTS * (DEPTH / RD_RATIO);
    localparam int IDX_W    = PTR_W + RAW;

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                wr_ready_q, wr_ready_d, rd_valid_q, rd_valid_d;
    logic [ID_WIDTH-1:0] rd_id_q, rd_id_d;
    logic [ID_WIDTH-1:0] tag_q [NUM_SLOTS];
    logic [ID_WIDTH-1:0] tag_d [NUM_SLOTS];
    logic                err_q, err_d;
    logic [LATENCY-1:0]  vld_q, vld_d;

    logic                wr_acc, commit_acc, rd_acc, rel_acc;
    logic [AW-1:0]       wr_bank;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic [RDW-1:0]      rd_word;

    assign wr_acc     = wr_en & wr_ready_q;
    assign commit_acc = wr_commit & wr_ready_q;
    assign rd_acc     = rd_en & rd_valid_q;
    assign rel_acc    = rd_release & rd_valid_q;

    assign wr_bank = wr_addr & AW'(RD_RATIO - 1);
    assign wr_idx  = {wr_ptr_q, RAW'(wr_addr >> BANK_LOG)};
    assign rd_idx  = {rd_ptr_q, rd_addr};

    // Slot bookkeeping: pointers, occupancy, tags, flags and error accumulation
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        tag_d    = tag_q;
        if (commit_acc) begin
            tag_d[wr_ptr_q] = wr_id;
            wr_ptr_d = (wr_ptr_q == PTR_W'(NUM_SLOTS - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rel_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(NUM_SLOTS - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (commit_acc && !rel_acc) occ_d = occ_q + OCC_W'(1);
        if (rel_acc && !commit_acc) occ_d = occ_q - OCC_W'(1);
        // Flags come from the post-cycle occupancy so they lag commit/release by one edge
        wr_ready_d = (occ_d < OCC_W'(NUM_SLOTS));
        rd_valid_d = (occ_d != '0);
        // New tag is visible here when the commit lands in the slot being read next
        rd_id_d    = tag_d[rd_ptr_d];
        err_d      = err_q
                   | (wr_en      & ~wr_ready_q)
                   | (wr_commit  & ~wr_ready_q)
                   | (rd_en      & ~rd_valid_q)
                   | (rd_release & ~rd_valid_q);
    end

    // Read-valid shift chain; accepted reads enter at stage 0
    always_comb begin
        vld_d[0] = rd_acc;
        for (int i = 1; i < LATENCY; i++) vld_d[i] = vld_q[i-1];
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            wr_ready_q <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
            err_q      <= 1'b0;
            vld_q      <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) tag_q[s] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            err_q      <= err_d;
            vld_q      <= vld_d;
            tag_q      <= tag_d;
        end
    end

    // One bank per lane of the wide read word; bank select is the low write-address bits
    for (genvar b = 0; b < RD_RATIO; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [ROWS];
        logic [DATA_WIDTH-1:0] bank_rd_q;
        logic                  bank_we;

        assign bank_we = wr_acc && (wr_bank == AW'(b));

        // Bank write port (contents intentionally not reset)
        always_ff @(posedge clk) begin
            if (bank_we) mem[wr_idx] <= wr_data;
        end

        // Bank read register: first pipeline stage, holds value between reads
        always_ff @(posedge clk) begin
            if (rst)         bank_rd_q <= '0;
            else if (rd_acc) bank_rd_q <= mem[rd_idx];
        end

        assign rd_word[b*DATA_WIDTH +: DATA_WIDTH] = bank_rd_q;
    end

    if (LATENCY == 1) begin : g_lat1
        assign rd_data = rd_word;
    end else begin : g_latn
        logic [RDW-1:0] stage_q [LATENCY-1];
        logic [RDW-1:0] stage_d [LATENCY-1];

        // Extra data stages advance only with valid data so rd_data holds otherwise
        always_comb begin
            stage_d[0] = vld_q[0] ? rd_word : stage_q[0];
            for (int i = 1; i < LATENCY - 1; i++) begin
                stage_d[i] = vld_q[i] ? stage_q[i-1] : stage_q[i];
            end
        end

        // Data stage registers
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < LATENCY - 1; i++) stage_q[i] <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign rd_data = stage_q[LATENCY-2];
    end

`ifdef PP_BUF_STALL_CNT_EN
    logic [31:0] wr_stall_q, wr_stall_d, rd_stall_q, rd_stall_d;

    // Saturating stall counters based on the pre-cycle flags
    always_comb begin
        wr_stall_d = wr_stall_q;
        rd_stall_d = rd_stall_q;
        if (!wr_ready_q && (wr_en || wr_commit) && (wr_stall_q != '1)) wr_stall_d = wr_stall_q + 32'd1;
        if (!rd_valid_q && rd_en && (rd_stall_q != '1))                rd_stall_d = rd_stall_q + 32'd1;
    end

    // Stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_stall_q <= '0;
            rd_stall_q <= '0;
        end else begin
            wr_stall_q <= wr_stall_d;
            rd_stall_q <= rd_stall_d;
        end
    end

    assign wr_stall_cnt = wr_stall_q;
    assign rd_stall_cnt = rd_stall_q;
`endif

    assign wr_ready    = wr_ready_q;
    assign rd_valid    = rd_valid_q;
    assign rd_id       = rd_id_q;
    assign rd_data_vld = vld_q[LATENCY-1];
    assign occupancy   = occ_q;
    assign err         = err_q;

endmodule
